ctrl: RTL and testbench

CTRL -- requirements
Module: ctrl

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_decoder.sv | 160 ++++++++++++++++
 rtl/ctrl.sv | 61 ++++++
 tb/tb_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants for the instruction controller: opcodes, output
// encodings, the decoded-control bundle and the bench clock half-period.
package ctrl_pkg;

  localparam int PERIOD_HALF = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SHIFT = 3'b010;
  localparam logic [2:0] ALU_CMP   = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPB_RS2  = 2'b00;
  localparam logic [1:0] OPB_IMM  = 2'b01;
  localparam logic [1:0] OPB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_CMP  = 2'b01;
  localparam logic [1:0] RES_UIMM = 2'b10;

  typedef struct packed {
    logic [1:0] size;
    logic       reg_wr_en;
    logic       wb;
    logic       jump;
    logic       load_sign;
    logic       store_en;
    logic [2:0] imm;
    logic [2:0] alu_op;
    logic [2:0] branch;
    logic [1:0] opa;
    logic [1:0] opb;
    logic [1:0] result;
    logic       sign;
    logic       shift_dir;
    logic       addr;
    logic       m_ext;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decode; any illegal combination yields an
// all-zero (NOP) control bundle.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct_3,
  input  logic [6:0] funct_7,
  output ctrl_out_t  dec
);

  logic       is_op;
  logic       alt;
  logic       alu_legal;
  logic [2:0] alu_op;
  logic       alu_sign;
  logic       alu_dir;
  logic [1:0] alu_res;

  assign is_op = (opcode == OPC_OP);
  assign alt   = (funct_7 == F7_ALT);

  // ALU field decode shared by OP and OP-IMM; funct7 only matters for OP or shifts
  always_comb begin
    alu_legal = 1'b1;
    alu_op    = ALU_ADD;
    alu_sign  = 1'b0;
    alu_dir   = 1'b0;
    alu_res   = RES_ALU;
    case (funct_3)
      3'b000: alu_op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        alu_op    = ALU_SHIFT;
        alu_legal = (funct_7 == F7_BASE);
      end
      3'b010: begin
        alu_op    = ALU_CMP;
        alu_sign  = 1'b1;
        alu_res   = RES_CMP;
        alu_legal = !(is_op && alt);
      end
      3'b011: begin
        alu_op    = ALU_CMP;
        alu_res   = RES_CMP;
        alu_legal = !(is_op && alt);
      end
      3'b100: begin
        alu_op    = ALU_XOR;
        alu_legal = !(is_op && alt);
      end
      3'b101: begin
        alu_op    = ALU_SHIFT;
        alu_dir   = 1'b1;
        alu_sign  = alt;
        alu_legal = (funct_7 == F7_BASE) || alt;
      end
      3'b110: begin
        alu_op    = ALU_OR;
        alu_legal = !(is_op && alt);
      end
      default: begin
        alu_op    = ALU_AND;
        alu_legal = !(is_op && alt);
      end
    endcase
  end

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_LUI: begin
        dec.reg_wr_en = 1'b1;
        dec.imm       = IMM_U;
        dec.result    = RES_UIMM;
      end
      OPC_AUIPC: begin
        dec.reg_wr_en = 1'b1;
        dec.imm       = IMM_U;
        dec.opa       = OPA_PC;
        dec.opb       = OPB_IMM;
      end
      OPC_JAL: begin
        dec.reg_wr_en = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = IMM_J;
        dec.opa       = OPA_PC;
        dec.opb       = OPB_FOUR;
      end
      OPC_JALR: begin
        if (funct_3 == 3'b000) begin
          dec.reg_wr_en = 1'b1;
          dec.jump      = 1'b1;
          dec.imm       = IMM_I;
          dec.opa       = OPA_PC;
          dec.opb       = OPB_FOUR;
          dec.addr      = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct_3[2:1] != 2'b01) begin
          dec.imm    = IMM_B;
          dec.alu_op = ALU_CMP;
          dec.sign   = (funct_3[2:1] == 2'b10);
          case (funct_3)
            3'b000:  dec.branch = BR_BEQ;
            3'b001:  dec.branch = BR_BNE;
            3'b100:  dec.branch = BR_BLT;
            3'b101:  dec.branch = BR_BGE;
            3'b110:  dec.branch = BR_BLTU;
            default: dec.branch = BR_BGEU;
          endcase
        end
      end
      OPC_LOAD: begin
        if (funct_3[1:0] != 2'b11 && !(funct_3[2] && funct_3[1])) begin
          dec.reg_wr_en = 1'b1;
          dec.wb        = 1'b1;
          dec.imm       = IMM_I;
          dec.opb       = OPB_IMM;
          dec.size      = funct_3[1:0];
          dec.load_sign = !funct_3[2];
        end
      end
      OPC_STORE: begin
        if (funct_3 <= 3'b010) begin
          dec.store_en = 1'b1;
          dec.imm      = IMM_S;
          dec.opb      = OPB_IMM;
          dec.size     = funct_3[1:0];
        end
      end
      OPC_OP_IMM: begin
        if (alu_legal) begin
          dec.reg_wr_en = 1'b1;
          dec.imm       = IMM_I;
          dec.opb       = OPB_IMM;
          dec.alu_op    = alu_op;
          dec.sign      = alu_sign;
          dec.shift_dir = alu_dir;
          dec.result    = alu_res;
        end
      end
      OPC_OP: begin
        if (funct_7 == F7_MEXT) begin
          dec.reg_wr_en = 1'b1;
          dec.m_ext     = 1'b1;
        end else if ((funct_7 == F7_BASE || alt) && alu_legal) begin
          dec.reg_wr_en = 1'b1;
          dec.opb       = OPB_RS2;
          dec.alu_op    = alu_op;
          dec.sign      = alu_sign;
          dec.shift_dir = alu_dir;
          dec.result    = alu_res;
        end
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/ctrl.sv
// Instruction controller top: registers the decoded control bundle so every
// output appears one cycle after its instruction fields are sampled.
module ctrl
  import ctrl_pkg::*;
(
  input  logic       ip_clk,
  input  logic       ip_rst,
  input  logic [6:0] ip_opcode,
  input  logic [2:0] ip_funct_3,
  input  logic [6:0] ip_funct_7,
  output logic [1:0] op_load_store_bit_ctrl,
  output logic       op_reg_wr_en,
  output logic       op_wb_ctrl,
  output logic       op_jump_ctrl,
  output logic       op_load_sign_ctrl,
  output logic       op_store_en,
  output logic [2:0] op_imm_ext_ctrl,
  output logic [2:0] op_ALU_operation_ctrl,
  output logic [2:0] op_ALU_branch_ctrl,
  output logic [1:0] op_ALU_operand_a_ctrl,
  output logic [1:0] op_ALU_operand_b_ctrl,
  output logic [1:0] op_ALU_result_ctrl,
  output logic       op_ALU_sign_ctrl,
  output logic       op_ALU_shift_direction_ctrl,
  output logic       op_ALU_addr_ctrl,
  output logic       op_m_ext_wb_ctrl
);

  ctrl_out_t dec;
  ctrl_out_t q;

  ctrl_decoder u_decoder (
    .opcode  (ip_opcode),
    .funct_3 (ip_funct_3),
    .funct_7 (ip_funct_7),
    .dec     (dec)
  );

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) q <= '0;
    else        q <= dec;
  end

  assign op_load_store_bit_ctrl      = q.size;
  assign op_reg_wr_en                = q.reg_wr_en;
  assign op_wb_ctrl                  = q.wb;
  assign op_jump_ctrl                = q.jump;
  assign op_load_sign_ctrl           = q.load_sign;
  assign op_store_en                 = q.store_en;
  assign op_imm_ext_ctrl             = q.imm;
  assign op_ALU_operation_ctrl       = q.alu_op;
  assign op_ALU_branch_ctrl          = q.branch;
  assign op_ALU_operand_a_ctrl       = q.opa;
  assign op_ALU_operand_b_ctrl       = q.opb;
  assign op_ALU_result_ctrl          = q.result;
  assign op_ALU_sign_ctrl            = q.sign;
  assign op_ALU_shift_direction_ctrl = q.shift_dir;
  assign op_ALU_addr_ctrl            = q.addr;
  assign op_m_ext_wb_ctrl            = q.m_ext;

endmodule

// File: tb/tb_ctrl.sv
// Directed bench for the instruction controller: hand-computed control vectors
// per instruction, plus async reset behaviour.
module tb_ctrl;
  import ctrl_pkg::*;

  logic       ip_clk_tb = 1'b0;
  logic       ip_rst;
  logic [6:0] ip_opcode;
  logic [2:0] ip_funct_3;
  logic [6:0] ip_funct_7;
  logic [1:0] size;
  logic       reg_wr_en, wb, jump, load_sign, store_en;
  logic [2:0] imm, alu_op, branch;
  logic [1:0] opa, opb, result;
  logic       sign, shift_dir, addr, m_ext;

  int n_cmp = 0;
  int n_err = 0;

  always #(PERIOD_HALF) ip_clk_tb = ~ip_clk_tb;

  ctrl dut (
    .ip_clk                      (ip_clk_tb),
    .ip_rst                      (ip_rst),
    .ip_opcode                   (ip_opcode),
    .ip_funct_3                  (ip_funct_3),
    .ip_funct_7                  (ip_funct_7),
    .op_load_store_bit_ctrl      (size),
    .op_reg_wr_en                (reg_wr_en),
    .op_wb_ctrl                  (wb),
    .op_jump_ctrl                (jump),
    .op_load_sign_ctrl           (load_sign),
    .op_store_en                 (store_en),
    .op_imm_ext_ctrl             (imm),
    .op_ALU_operation_ctrl       (alu_op),
    .op_ALU_branch_ctrl          (branch),
    .op_ALU_operand_a_ctrl       (opa),
    .op_ALU_operand_b_ctrl       (opb),
    .op_ALU_result_ctrl          (result),
    .op_ALU_sign_ctrl            (sign),
    .op_ALU_shift_direction_ctrl (shift_dir),
    .op_ALU_addr_ctrl            (addr),
    .op_m_ext_wb_ctrl            (m_ext)
  );

  logic [25:0] obs;
  assign obs = {size, reg_wr_en, wb, jump, load_sign, store_en, imm, alu_op, branch,
                opa, opb, result, sign, shift_dir, addr, m_ext};

  // Field order: size wr wb jump lsign st imm op br a b res sign dir addr m
  function automatic logic [25:0] vec(
    input logic [1:0] sz, input logic wr, input logic w, input logic j,
    input logic ls, input logic st, input logic [2:0] im, input logic [2:0] op,
    input logic [2:0] br, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] res, input logic sg, input logic dr, input logic ad,
    input logic m);
    return {sz, wr, w, j, ls, st, im, op, br, a, b, res, sg, dr, ad, m};
  endfunction

  task automatic chk(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [25:0] exp);
    ip_opcode  = opc;
    ip_funct_3 = f3;
    ip_funct_7 = f7;
    @(posedge ip_clk_tb);
    #1;
    chk(tag, obs, exp);
  endtask

  initial begin
    ip_rst = 1'b1;
    ip_opcode = 7'b0110111;
    ip_funct_3 = 3'b000;
    ip_funct_7 = 7'b0000000;
    repeat (2) @(posedge ip_clk_tb);
    #1;
    chk("reset", obs, '0);
    @(negedge ip_clk_tb);
    ip_rst = 1'b0;

    apply("lui",      7'b0110111, 3'b100, 7'b1001011, vec(2'b00,1,0,0,0,0,3'b011,3'b000,3'b000,2'b00,2'b00,2'b10,0,0,0,0));
    apply("auipc",    7'b0010111, 3'b000, 7'b0000000, vec(2'b00,1,0,0,0,0,3'b011,3'b000,3'b000,2'b01,2'b01,2'b00,0,0,0,0));
    apply("jal",      7'b1101111, 3'b111, 7'b0000000, vec(2'b00,1,0,1,0,0,3'b100,3'b000,3'b000,2'b01,2'b10,2'b00,0,0,0,0));
    apply("jalr",     7'b1100111, 3'b000, 7'b0000000, vec(2'b00,1,0,1,0,0,3'b000,3'b000,3'b000,2'b01,2'b10,2'b00,0,0,1,0));
    apply("jalr_bad", 7'b1100111, 3'b001, 7'b0000000, '0);
    apply("bge",      7'b1100011, 3'b101, 7'b0000000, vec(2'b00,0,0,0,0,0,3'b010,3'b011,3'b100,2'b00,2'b00,2'b00,1,0,0,0));
    apply("beq",      7'b1100011, 3'b000, 7'b0000000, vec(2'b00,0,0,0,0,0,3'b010,3'b011,3'b001,2'b00,2'b00,2'b00,0,0,0,0));
    apply("bltu",     7'b1100011, 3'b110, 7'b0000000, vec(2'b00,0,0,0,0,0,3'b010,3'b011,3'b101,2'b00,2'b00,2'b00,0,0,0,0));
    apply("br_bad",   7'b1100011, 3'b010, 7'b0000000, '0);
    apply("lbu",      7'b0000011, 3'b100, 7'b0000000, vec(2'b00,1,1,0,0,0,3'b000,3'b000,3'b000,2'b00,2'b01,2'b00,0,0,0,0));
    apply("lw",       7'b0000011, 3'b010, 7'b0000000, vec(2'b10,1,1,0,1,0,3'b000,3'b000,3'b000,2'b00,2'b01,2'b00,0,0,0,0));
    apply("ld_bad",   7'b0000011, 3'b011, 7'b0000000, '0);
    apply("sh",       7'b0100011, 3'b001, 7'b0000000, vec(2'b01,0,0,0,0,1,3'b001,3'b000,3'b000,2'b00,2'b01,2'b00,0,0,0,0));
    apply("st_bad",   7'b0100011, 3'b011, 7'b0000000, '0);
    apply("slti",     7'b0010011, 3'b010, 7'b0000000, vec(2'b00,1,0,0,0,0,3'b000,3'b011,3'b000,2'b00,2'b01,2'b01,1,0,0,0));
    apply("srai",     7'b0010011, 3'b101, 7'b0100000, vec(2'b00,1,0,0,0,0,3'b000,3'b010,3'b000,2'b00,2'b01,2'b00,1,1,0,0));
    apply("slli_bad", 7'b0010011, 3'b001, 7'b0100000, '0);
    apply("andi",     7'b0010011, 3'b111, 7'b1111111, vec(2'b00,1,0,0,0,0,3'b000,3'b110,3'b000,2'b00,2'b01,2'b00,0,0,0,0));
    apply("sra",      7'b0110011, 3'b101, 7'b0100000, vec(2'b00,1,0,0,0,0,3'b000,3'b010,3'b000,2'b00,2'b00,2'b00,1,1,0,0));
    apply("sub",      7'b0110011, 3'b000, 7'b0100000, vec(2'b00,1,0,0,0,0,3'b000,3'b001,3'b000,2'b00,2'b00,2'b00,0,0,0,0));
    apply("xor_bad",  7'b0110011, 3'b100, 7'b0100000, '0);
    apply("mul",      7'b0110011, 3'b000, 7'b0000001, vec(2'b00,1,0,0,0,0,3'b000,3'b000,3'b000,2'b00,2'b00,2'b00,0,0,0,1));
    apply("sltu",     7'b0110011, 3'b011, 7'b0000000, vec(2'b00,1,0,0,0,0,3'b000,3'b011,3'b000,2'b00,2'b00,2'b01,0,0,0,0));
    apply("op_bad",   7'b0110011, 3'b000, 7'b0000010, '0);
    apply("unknown",  7'b1111111, 3'b000, 7'b0000000, '0);

    // mid-stream async reset during a decoded SW
    apply("sw",       7'b0100011, 3'b010, 7'b0000000, vec(2'b10,0,0,0,0,1,3'b001,3'b000,3'b000,2'b00,2'b01,2'b00,0,0,0,0));
    #2;
    ip_rst = 1'b1;
    #1;
    chk("rst_async_store", {25'd0, store_en}, 26'd0);
    chk("rst_async_all", obs, '0);
    apply("rst_held", 7'b0110111, 3'b000, 7'b0000000, '0);
    @(negedge ip_clk_tb);
    ip_rst = 1'b0;
    apply("post_rst", 7'b0110111, 3'b000, 7'b0000000, vec(2'b00,1,0,0,0,0,3'b011,3'b000,3'b000,2'b00,2'b00,2'b10,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
